// File: rtl/branch_resolve_unit_if.sv
// Interface for the branch resolve unit: the EX-stage operands and flags,
// the redirect handshake towards fetch, the squash controls and the
// performance counters.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 32
);
  logic             ex_valid;
  logic [3:0]       ex_br_type;
  logic             ex_zero;
  logic             ex_sign;
  logic             ex_overflow;
  logic             ex_carry;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_imm;
  logic [31:0]      ex_rs1;
  logic             redirect_ready;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_if_id;
  logic             kill_ex;
  logic             misalign_err;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  // Driver side: EX stage and fetch
  modport master (
    output ex_valid, ex_br_type, ex_zero, ex_sign, ex_overflow, ex_carry,
    output ex_pc, ex_imm, ex_rs1, redirect_ready,
    input  redirect_valid, redirect_pc, flush_if_id, kill_ex, misalign_err,
    input  br_cnt, taken_cnt
  );

  // Resolve-unit side
  modport slave (
    input  ex_valid, ex_br_type, ex_zero, ex_sign, ex_overflow, ex_carry,
    input  ex_pc, ex_imm, ex_rs1, redirect_ready,
    output redirect_valid, redirect_pc, flush_if_id, kill_ex, misalign_err,
    output br_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch/jump outcomes in EX under a static
// predict-not-taken scheme, requests a fetch redirect for taken transfers,
// squashes wrong-path work while the redirect is pending and keeps
// saturating branch/taken counters.
module branch_resolve_unit #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  branch_resolve_unit_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             misalign_q, misalign_d;

  logic             is_branch;
  logic             cond;
  logic [31:0]      target;
  logic             resolve;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Decode the branch type and evaluate its condition from the ALU flags
  always_comb begin
    is_branch = 1'b0;
    cond      = 1'b0;
    case (bus.ex_br_type)
      4'd1: begin is_branch = 1'b1; cond = bus.ex_zero;                     end
      4'd2: begin is_branch = 1'b1; cond = ~bus.ex_zero;                    end
      4'd3: begin is_branch = 1'b1; cond = bus.ex_sign ^ bus.ex_overflow;   end
      4'd4: begin is_branch = 1'b1; cond = ~(bus.ex_sign ^ bus.ex_overflow); end
      4'd5: begin is_branch = 1'b1; cond = bus.ex_carry;                    end
      4'd6: begin is_branch = 1'b1; cond = ~bus.ex_carry;                   end
      4'd7,
      4'd8: begin is_branch = 1'b1; cond = 1'b1;                            end
      default: begin is_branch = 1'b0; cond = 1'b0;                         end
    endcase
  end

  // Target address: JALR is register-relative with bit 0 cleared
  always_comb begin
    if (bus.ex_br_type == 4'd8) begin
      target = (bus.ex_rs1 + bus.ex_imm) & ~32'h1;
    end else begin
      target = bus.ex_pc + bus.ex_imm;
    end
  end

  // While a redirect is pending the EX slot is wrong-path and is ignored
  assign resolve = (state_q == IDLE) && bus.ex_valid && is_branch;

  // Next-state, redirect target, counter and misalign-pulse logic
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    br_cnt_d      = br_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    misalign_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (resolve) begin
          br_cnt_d = sat_inc(br_cnt_q);
          if (cond) begin
            if (!target[1]) begin
              redirect_pc_d = target;
              taken_cnt_d   = sat_inc(taken_cnt_q);
              state_d       = REQ;
            end else begin
              // Misaligned target: report it, but keep fetching sequentially
              misalign_d = 1'b1;
            end
          end
        end
      end
      REQ: begin
        if (bus.redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      redirect_pc_q <= 32'h0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
      misalign_q    <= misalign_d;
    end
  end

  // Squash controls are a pure function of the registered state
  assign bus.redirect_valid = (state_q == REQ);
  assign bus.flush_if_id    = (state_q == REQ);
  assign bus.kill_ex        = (state_q == REQ);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.misalign_err   = misalign_q;
  assign bus.br_cnt         = br_cnt_q;
  assign bus.taken_cnt      = taken_cnt_q;

endmodule
